midi_note_parser: RTL and testbench
===================================

MIDI_NOTE_PARSER -- requirements
Module: midi_note_parser

Interface
REQ-001 Parameter OMNI, default 0: 1 = accept all channels, ignore channel input.
REQ-002 clk  input  1  rising-edge system clock, single clock domain.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rx_byte  input  8  received MIDI byte from UART.
REQ-005 rx_valid  input  1  one-cycle strobe, rx_byte valid; one byte per strobe.
REQ-006 channel  input  4  MIDI channel to accept (0-15).
REQ-007 note_on  output  1  one-cycle pulse, note start to envelope generator.
REQ-008 note_off  output  1  one-cycle pulse, release to envelope generator.
REQ-009 note  output  7  currently held note number, registered.
REQ-010 velocity  output  7  velocity of last accepted note-on, registered.
REQ-011 gate  output  1  high while a note is held.

Function
REQ-012 The block shall implement states IDLE (await status), NOTE (await key byte), VEL (await velocity byte) and SKIP (discard data bytes of other messages).
REQ-013 Bytes shall be examined only in cycles with rx_valid=1; the state shall not change otherwise.
REQ-014 Status 0x8n/0x9n with n==channel (or OMNI=1) shall go to NOTE and latch message type; other-channel or other 0x80-0xEF status shall go to SKIP.
REQ-015 SKIP data-byte count shall be 1 for 0xCn/0xDn and 2 otherwise, then return to IDLE.
REQ-016 Status 0xF0-0xF7 shall force IDLE and clear the stored running status; 0xF8-0xFF (realtime) shall be ignored with no state or data change in any state.
REQ-017 A status byte (bit7=1, not realtime) arriving in NOTE, VEL or SKIP shall abort the message and be processed as a new status.
REQ-018 NOTE shall latch bits [6:0] as key and go to VEL; VEL shall latch velocity and go to IDLE.
REQ-019 Note-on with velocity>0 shall, in the cycle after the velocity strobe, pulse note_on, load note and velocity, set gate.
REQ-020 Note-on with a different note while gate=1 (legato) shall update note and velocity and pulse note_on without note_off.
REQ-021 0x8n, or 0x9n with velocity 0, shall pulse note_off and clear gate only when gate=1 and key==note; otherwise no output change.
REQ-022 note_on and note_off shall never be high in the same cycle; each pulse shall last exactly one cycle.
REQ-023 Data byte (bit7=0) in IDLE shall be handled per REQ-032/033.

Reset
REQ-024 rst=1 on a clk edge shall set state IDLE, note_on=0, note_off=0, note=0, velocity=0, gate=0, running status cleared.
REQ-025 Reset mid-message shall discard the partial message and emit no pulse; the first byte after reset requires a fresh status.

Configuration
REQ-026 Macro MIDI_RUNNING_STATUS_EN selects running-status support.
REQ-027 Defined: last accepted channel-voice status (0x80-0xEF) shall be retained.
REQ-028 Defined: a data byte in IDLE shall be treated as first data byte of the retained status (NOTE or SKIP with one byte consumed).
REQ-029 Defined: a 0xF0-0xF7 status shall clear the retained status.
REQ-030 Undefined: no status shall be retained.
REQ-031 Undefined: data bytes in IDLE shall be discarded.
REQ-032 With a retained status, REQ-023 follows REQ-028.
REQ-033 Without a retained status, REQ-023 follows REQ-031.

Verification
REQ-034 channel=2: 0x92,0x3C,0x64 -> note_on pulse 1 cycle after third strobe, note=0x3C, velocity=0x64, gate=1.
REQ-035 Then 0x82,0x3C,0x00 -> note_off pulse, gate=0; instead 0x82,0x40,0x00 -> no pulse, gate stays 1.
REQ-036 0x92,0x3C,0xF8,0x50 -> realtime ignored, note_on with velocity=0x50.
REQ-037 0x93,0x3C,0x64 with channel=2, OMNI=0 -> no pulse; OMNI=1 -> note_on.
REQ-038 MIDI_RUNNING_STATUS_EN defined: 0x92,0x3C,0x64,0x3C,0x00 -> note_on then note_off; undefined -> note_on only.
REQ-039 rst asserted between 0x92 and 0x3C, then 0x3C,0x64 -> no pulse, all outputs 0.

Source files
------------

// File: rtl/midi_note_parser_if.sv
// MIDI note parser bus: UART byte strobe in,
// note events and held-note state out.
interface midi_note_parser_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [3:0] channel;
  logic       note_on;
  logic       note_off;
  logic [6:0] note;
  logic [6:0] velocity;
  logic       gate;

  modport master (
    output rx_byte, rx_valid, channel,
    input  note_on, note_off, note, velocity, gate
  );

  modport slave (
    input  rx_byte, rx_valid, channel,
    output note_on, note_off, note, velocity, gate
  );
endinterface

// File: rtl/midi_note_parser.sv
// MIDI note-on/off parser for a mono voice.
// Define MIDI_RUNNING_STATUS_EN for running status.
module midi_note_parser #(
  parameter bit OMNI = 1'b0
) (
  input logic               clk,
  input logic               rst,
  midi_note_parser_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    NOTE,
    VEL,
    SKIP
  } state_t;

  state_t     r_state, w_state_nx;
  logic       r_is_on, w_is_on_nx;
  logic [6:0] r_key, w_key_nx;
  logic [1:0] r_cnt, w_cnt_nx;
  logic       r_note_on, w_note_on_nx;
  logic       r_note_off, w_note_off_nx;
  logic [6:0] r_note, w_note_nx;
  logic [6:0] r_vel, w_vel_nx;
  logic       r_gate, w_gate_nx;

  logic       w_strobe;
  logic       w_sys;
  logic [7:0] w_byte;

  assign w_byte   = bus.rx_byte;
  assign w_strobe = bus.rx_valid &&
                    (w_byte[7:3] != 5'b11111);
  assign w_sys    = (w_byte[7:3] == 5'b11110);

  function automatic logic f_acc(
    input logic [7:0] s,
    input logic [3:0] ch
  );
    return (s[7:5] == 3'b100) &&
           (OMNI || (s[3:0] == ch));
  endfunction

  function automatic logic [1:0] f_len(
    input logic [7:0] s
  );
    return (s[7:5] == 3'b110) ? 2'd1 : 2'd2;
  endfunction

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] r_rs;
  logic       r_rs_vld;
  logic       w_rs_set;
  logic       w_rs_clr;

  // Retain last channel-voice status byte
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rs     <= 8'h00;
      r_rs_vld <= 1'b0;
    end else if (w_rs_clr) begin
      r_rs_vld <= 1'b0;
    end else if (w_rs_set) begin
      r_rs     <= w_byte;
      r_rs_vld <= 1'b1;
    end
  end
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_is_on    <= 1'b0;
      r_key      <= 7'd0;
      r_cnt      <= 2'd0;
      r_note_on  <= 1'b0;
      r_note_off <= 1'b0;
      r_note     <= 7'd0;
      r_vel      <= 7'd0;
      r_gate     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_is_on    <= w_is_on_nx;
      r_key      <= w_key_nx;
      r_cnt      <= w_cnt_nx;
      r_note_on  <= w_note_on_nx;
      r_note_off <= w_note_off_nx;
      r_note     <= w_note_nx;
      r_vel      <= w_vel_nx;
      r_gate     <= w_gate_nx;
    end
  end

  // Byte decode, next state and note events
  always_comb begin
    w_state_nx    = r_state;
    w_is_on_nx    = r_is_on;
    w_key_nx      = r_key;
    w_cnt_nx      = r_cnt;
    w_note_on_nx  = 1'b0;
    w_note_off_nx = 1'b0;
    w_note_nx     = r_note;
    w_vel_nx      = r_vel;
    w_gate_nx     = r_gate;
`ifdef MIDI_RUNNING_STATUS_EN
    w_rs_set      = 1'b0;
    w_rs_clr      = 1'b0;
`endif
    if (w_strobe) begin
      if (w_byte[7]) begin
        if (w_sys) begin
          w_state_nx = IDLE;
`ifdef MIDI_RUNNING_STATUS_EN
          w_rs_clr   = 1'b1;
`endif
        end else begin
`ifdef MIDI_RUNNING_STATUS_EN
          w_rs_set = 1'b1;
`endif
          if (f_acc(w_byte, bus.channel)) begin
            w_state_nx = NOTE;
            w_is_on_nx = w_byte[4];
          end else begin
            w_state_nx = SKIP;
            w_cnt_nx   = f_len(w_byte);
          end
        end
      end else begin
        unique case (r_state)
          IDLE: begin
`ifdef MIDI_RUNNING_STATUS_EN
            if (r_rs_vld) begin
              if (f_acc(r_rs, bus.channel)) begin
                w_key_nx   = w_byte[6:0];
                w_is_on_nx = r_rs[4];
                w_state_nx = VEL;
              end else if (f_len(r_rs) == 2'd2) begin
                w_state_nx = SKIP;
                w_cnt_nx   = 2'd1;
              end
            end
`endif
          end
          NOTE: begin
            w_key_nx   = w_byte[6:0];
            w_state_nx = VEL;
          end
          VEL: begin
            w_state_nx = IDLE;
            if (r_is_on && (w_byte[6:0] != 7'd0)) begin
              w_note_on_nx = 1'b1;
              w_note_nx    = r_key;
              w_vel_nx     = w_byte[6:0];
              w_gate_nx    = 1'b1;
            end else if (r_gate && (r_key == r_note)) begin
              w_note_off_nx = 1'b1;
              w_gate_nx     = 1'b0;
            end
          end
          SKIP: begin
            w_cnt_nx = r_cnt - 2'd1;
            if (r_cnt <= 2'd1) begin
              w_state_nx = IDLE;
            end
          end
        endcase
      end
    end
  end

  assign bus.note_on  = r_note_on;
  assign bus.note_off = r_note_off;
  assign bus.note     = r_note;
  assign bus.velocity = r_vel;
  assign bus.gate     = r_gate;

endmodule

// File: tb/tb_midi_note_parser.sv
// Scoreboard bench: channel-filtered and OMNI
// parsers fed the same byte stream.
module tb_midi_note_parser;

  logic clk;
  logic rst;
  int   cyc;
  int   nchk;
  int   nerr;

  typedef struct {
    bit         ok;
    bit         on;
    logic [6:0] n;
    logic [6:0] v;
    bit         g;
    int         cyc;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  midi_note_parser_if bus0 ();
  midi_note_parser_if bus1 ();

  midi_note_parser #(.OMNI(1'b0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  midi_note_parser #(.OMNI(1'b1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic cmp(
    input string      tag,
    input ev_t        e,
    input logic       on,
    input logic       off,
    input logic [6:0] n,
    input logic [6:0] v,
    input logic       g
  );
    chk({tag, "_excl"}, 32'(on & off), 0);
    if (!e.ok) begin
      chk({tag, "_unexp"}, {30'd0, on, off}, 0);
    end else begin
      chk({tag, "_cyc"}, cyc, e.cyc);
      chk({tag, "_kind"}, 32'(on), 32'(e.on));
      chk({tag, "_note"}, 32'(n), 32'(e.n));
      if (e.on) chk({tag, "_vel"}, 32'(v), 32'(e.v));
      chk({tag, "_gate"}, 32'(g), 32'(e.g));
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (bus0.note_on || bus0.note_off) begin
      e = '{default: 0};
      if (q0.size() > 0) e = q0.pop_front();
      cmp("d0", e, bus0.note_on, bus0.note_off,
          bus0.note, bus0.velocity, bus0.gate);
    end
    if (bus1.note_on || bus1.note_off) begin
      e = '{default: 0};
      if (q1.size() > 0) e = q1.pop_front();
      cmp("d1", e, bus1.note_on, bus1.note_off,
          bus1.note, bus1.velocity, bus1.gate);
    end
  end

  // expectation for the pulse caused by the next byte
  task automatic exp(
    input bit         d0,
    input bit         d1,
    input bit         on,
    input logic [6:0] n,
    input logic [6:0] v
  );
    ev_t e;
    e.ok  = 1'b1;
    e.on  = on;
    e.n   = n;
    e.v   = v;
    e.g   = on;
    e.cyc = cyc + 1;
    if (d0) q0.push_back(e);
    if (d1) q1.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    bus0.rx_byte  = b;
    bus1.rx_byte  = b;
    bus0.rx_valid = 1'b1;
    bus1.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus0.rx_valid = 1'b0;
    bus1.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic outs(
    input string      tag,
    input logic [6:0] n,
    input logic [6:0] v,
    input logic       g
  );
    chk({tag, "_n0"}, 32'(bus0.note), 32'(n));
    chk({tag, "_v0"}, 32'(bus0.velocity), 32'(v));
    chk({tag, "_g0"}, 32'(bus0.gate), 32'(g));
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    rst  = 1'b1;
    bus0.rx_byte  = 8'h00;
    bus1.rx_byte  = 8'h00;
    bus0.rx_valid = 1'b0;
    bus1.rx_valid = 1'b0;
    bus0.channel  = 4'd2;
    bus1.channel  = 4'd2;
    idle(3);
    rst = 1'b0;
    idle(1);
    outs("rst", 7'd0, 7'd0, 1'b0);
    chk("rst_on", 32'(bus0.note_on), 0);
    chk("rst_off", 32'(bus0.note_off), 0);
    chk("rst_g1", 32'(bus1.gate), 0);

    // basic note-on, with idle gaps
    send(8'h92);
    idle(2);
    send(8'h3C);
    exp(1, 1, 1, 7'h3C, 7'h64);
    send(8'h64);
    idle(2);
    outs("on1", 7'h3C, 7'h64, 1'b1);

    // note-off for a different key: ignored
    send(8'h82);
    send(8'h40);
    send(8'h00);
    idle(2);
    outs("offx", 7'h3C, 7'h64, 1'b1);

    // matching note-off
    send(8'h82);
    send(8'h3C);
    exp(1, 1, 0, 7'h3C, 7'h64);
    send(8'h00);
    idle(2);
    outs("off1", 7'h3C, 7'h64, 1'b0);

    // realtime byte inside a message
    send(8'h92);
    send(8'h3C);
    send(8'hF8);
    exp(1, 1, 1, 7'h3C, 7'h50);
    send(8'h50);
    idle(1);

    // legato, then velocity-0 note-on releases
    send(8'h92);
    send(8'h40);
    exp(1, 1, 1, 7'h40, 7'h30);
    send(8'h30);
    send(8'h92);
    send(8'h40);
    exp(1, 1, 0, 7'h40, 7'h30);
    send(8'h00);
    idle(1);
    outs("leg", 7'h40, 7'h30, 1'b0);

    // other channel: OMNI only
    send(8'h93);
    send(8'h3C);
    exp(0, 1, 1, 7'h3C, 7'h64);
    send(8'h64);
    send(8'h83);
    send(8'h3C);
    exp(0, 1, 0, 7'h3C, 7'h64);
    send(8'h00);
    idle(1);
    chk("omni_g1", 32'(bus1.gate), 0);

    // skipped controller message, then note-on
    send(8'hB2);
    send(8'h10);
    send(8'h20);
    send(8'hC2);
    send(8'h05);
    send(8'h92);
    send(8'h3C);
    exp(1, 1, 1, 7'h3C, 7'h64);
    send(8'h64);

    // status aborts a partial message
    send(8'h82);
    send(8'h3C);
    send(8'h92);
    send(8'h3D);
    exp(1, 1, 1, 7'h3D, 7'h40);
    send(8'h40);
    idle(1);
    outs("abort", 7'h3D, 7'h40, 1'b1);

    // sysex status drops the message and status
    send(8'h82);
    send(8'hF0);
    send(8'h3D);
    send(8'h00);
    idle(1);
    outs("sysx", 7'h3D, 7'h40, 1'b1);
    send(8'h82);
    send(8'h3D);
    exp(1, 1, 0, 7'h3D, 7'h40);
    send(8'h00);
    idle(1);

    // running status
    send(8'h92);
    send(8'h3C);
    exp(1, 1, 1, 7'h3C, 7'h64);
    send(8'h64);
    send(8'h3C);
`ifdef MIDI_RUNNING_STATUS_EN
    exp(1, 1, 0, 7'h3C, 7'h64);
    send(8'h00);
    idle(1);
    chk("rs_g", 32'(bus0.gate), 0);
`else
    send(8'h00);
    idle(1);
    chk("rs_g", 32'(bus0.gate), 1);
    send(8'h82);
    send(8'h3C);
    exp(1, 1, 0, 7'h3C, 7'h64);
    send(8'h00);
    idle(1);
`endif

    // reset mid-message
    send(8'h92);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    send(8'h3C);
    send(8'h64);
    idle(2);
    outs("rstm", 7'd0, 7'd0, 1'b0);
    chk("rstm_g1", 32'(bus1.gate), 0);
    chk("rstm_n1", 32'(bus1.note), 0);

    idle(3);
    chk("q0_left", q0.size(), 0);
    chk("q1_left", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
